dmem_axi_master: RTL

Data-side AXI4-Lite request master sitting between the EXU and the LSU. It accepts one load or store per handshake from the EXU and drives the AR or AW/W channels. It forwards the R/B responses to the LSU and keeps exactly one transaction outstanding. After a pipeline flush it drains any in-flight response itself, so the LSU never sees a stale beat.

---
 rtl/dmem_axi_master.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_axi_master.sv
// Data-side AXI4-Lite master: one load/store outstanding; responses from flushed ops are drained internally.
// Latency: accept N -> AR/AW/W valid N+1; minimum load returns to IDLE at N+3.
// Backpressure: req_ready_o low while busy; channel valids held until the slave handshakes. Option: DMEM_MISALIGN_CHECK_EN.
module dmem_axi_master (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [3:0]  req_re_i,
  input  logic [1:0]  req_size_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic [31:0] araddr_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  output logic [31:0] awaddr_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic        rvalid_i,
  output logic        rready_o,
  input  logic [1:0]  bresp_i,
  input  logic        bvalid_i,
  output logic        bready_o,
  output logic [31:0] lsu_rdata_o,
  output logic [1:0]  lsu_rresp_o,
  output logic        lsu_rvalid_o,
  input  logic        lsu_rready_i,
  output logic [1:0]  lsu_bresp_o,
  output logic        lsu_bvalid_o,
  input  logic        lsu_bready_i,
  output logic        ld_misalign_o,
  output logic        st_misalign_o
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_ADDR = 3'd1;
  localparam logic [2:0] WR_ADDR = 3'd2;
  localparam logic [2:0] WAIT_R  = 3'd3;
  localparam logic [2:0] WAIT_B  = 3'd4;

  logic [2:0]  state;
  logic        drain;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        arvalid_q, awvalid_q, wvalid_q;
  logic        aw_done, w_done;
  logic        accept, misaligned, drop;
  logic        aw_fin, w_fin;
  logic [31:0] wdata_enc;
  logic [3:0]  wstrb_enc;

  assign req_ready_o = (state == IDLE) && !flush;
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    wdata_enc = req_wdata_i;
    wstrb_enc = 4'b1111;
    if (req_size_i == 2'b00) begin
      wdata_enc = {4{req_wdata_i[7:0]}};
      wstrb_enc = 4'b0001 << req_addr_i[1:0];
    end else if (req_size_i == 2'b01) begin
      wdata_enc = {2{req_wdata_i[15:0]}};
      wstrb_enc = 4'b0011 << req_addr_i[1:0];
    end
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  logic ld_mis_q, st_mis_q;
  logic ld_half, ld_word;

  assign ld_half = (req_re_i == 4'b0111) || (req_re_i == 4'b0011);
  assign ld_word = (req_re_i == 4'b1111);
  assign misaligned = req_we_i
    ? ((req_size_i == 2'b01 && req_addr_i[0]) || (req_size_i[1] && req_addr_i[1:0] != 2'b00))
    : ((ld_half && req_addr_i[0]) || (ld_word && req_addr_i[1:0] != 2'b00));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ld_mis_q <= 1'b0;
      st_mis_q <= 1'b0;
    end else begin
      ld_mis_q <= accept && misaligned && !req_we_i;
      st_mis_q <= accept && misaligned && req_we_i;
    end
  end

  assign ld_misalign_o = ld_mis_q;
  assign st_misalign_o = st_mis_q;
`else
  assign misaligned    = 1'b0;
  assign ld_misalign_o = 1'b0;
  assign st_misalign_o = 1'b0;
`endif

  // A flush in the response cycle drops that beat just like a drained one.
  assign drop   = drain || flush;
  assign aw_fin = aw_done || (awvalid_q && awready_i);
  assign w_fin  = w_done || (wvalid_q && wready_i);

  assign araddr_o  = addr_q;
  assign arvalid_o = arvalid_q;
  assign awaddr_o  = addr_q;
  assign awvalid_o = awvalid_q;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = wstrb_q;
  assign wvalid_o  = wvalid_q;

  assign lsu_rdata_o  = rdata_i;
  assign lsu_rresp_o  = rresp_i;
  assign lsu_rvalid_o = rvalid_i && (state == WAIT_R) && !drop;
  assign rready_o     = drop ? 1'b1 : lsu_rready_i;
  assign lsu_bresp_o  = bresp_i;
  assign lsu_bvalid_o = bvalid_i && (state == WAIT_B) && !drop;
  assign bready_o     = drop ? 1'b1 : lsu_bready_i;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      drain     <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q  <= req_addr_i;
            wdata_q <= wdata_enc;
            wstrb_q <= wstrb_enc;
            if (misaligned) begin
              state <= IDLE;
            end else if (req_we_i) begin
              state     <= WR_ADDR;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done   <= 1'b0;
              w_done    <= 1'b0;
            end else if (|req_re_i) begin
              state     <= RD_ADDR;
              arvalid_q <= 1'b1;
            end
          end
        end
        RD_ADDR: begin
          if (flush) drain <= 1'b1;
          if (arready_i) begin
            arvalid_q <= 1'b0;
            state     <= WAIT_R;
          end
        end
        WR_ADDR: begin
          if (flush) drain <= 1'b1;
          if (awvalid_q && awready_i) begin
            awvalid_q <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (wvalid_q && wready_i) begin
            wvalid_q <= 1'b0;
            w_done   <= 1'b1;
          end
          if (aw_fin && w_fin) state <= WAIT_B;
        end
        WAIT_R: begin
          if (rvalid_i && rready_o) begin
            state <= IDLE;
            drain <= 1'b0;
          end else if (flush) begin
            drain <= 1'b1;
          end
        end
        WAIT_B: begin
          if (bvalid_i && bready_o) begin
            state <= IDLE;
            drain <= 1'b0;
          end else if (flush) begin
            drain <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
